muldiv_unit: RTL

Iterative multiply/divide unit with architectural HI/LO registers for the MIPS execute stage. It sits beside the ALU, takes the same rs/rt operands, and runs MULT, MULTU, DIV and DIVU over multiple cycles. It holds the 64-bit product or quotient/remainder in HI/LO for MFHI/MFLO. Control stalls the pipeline on `busy` and uses `done` to release the stall.

---
 rtl/muldiv_pkg.sv | 21 ++
 rtl/muldiv_divider.sv | 55 +++++
 rtl/muldiv_unit.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit (muldiv_unit).
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } muldiv_state_t;

  localparam int          MULDIV_ITER    = 32;
  localparam int          MULDIV_CNT_W   = $clog2(MULDIV_ITER);
  localparam logic [31:0] MULDIV_DIV0_LO = 32'hFFFF_FFFF;

endpackage

// File: rtl/muldiv_divider.sv
// Restoring-divide iteration register and step logic; compiled only when MULDIV_DIV_EN is defined.
`ifdef MULDIV_DIV_EN
module muldiv_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] quo_nxt_o,
  output logic [WIDTH-1:0] rem_nxt_o
);

  logic [WIDTH:0]   rem_q, rem_d, rem_step;
  logic [WIDTH-1:0] quo_q, quo_d, dvsr_q, dvsr_d;
  logic [WIDTH+1:0] shifted;
  logic             fits;

  // Quotient register doubles as the dividend shifter: its MSB feeds the remainder.
  always_comb begin
    shifted  = {rem_q, quo_q[WIDTH-1]};
    fits     = shifted >= (WIDTH+2)'(dvsr_q);
    rem_step = fits ? (WIDTH+1)'(shifted - (WIDTH+2)'(dvsr_q)) : (WIDTH+1)'(shifted);
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    if (load_i) begin
      rem_d  = '0;
      quo_d  = dividend_i;
      dvsr_d = divisor_i;
    end else if (step_i) begin
      rem_d = rem_step;
      quo_d = {quo_q[WIDTH-2:0], fits};
    end
  end

  assign quo_nxt_o = {quo_q[WIDTH-2:0], fits};
  assign rem_nxt_o = rem_step[WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvsr_q <= '0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvsr_q <= dvsr_d;
    end
  end

endmodule
`endif

// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit with HI/LO registers.
// Divide support is built only when MULDIV_DIV_EN is defined.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [MULDIV_CNT_W-1:0] CNT_LAST = MULDIV_CNT_W'(MULDIV_ITER - 1);

  muldiv_op_t              op_e;
  muldiv_state_t           state_q, state_d;
  logic [MULDIV_CNT_W-1:0] cnt_q, cnt_d;
  logic [2*WIDTH-1:0]      acc_q, acc_d, acc_step, prod;
  logic [WIDTH:0]          psum;
  logic [WIDTH-1:0]        mcand_q, mcand_d, hi_q, hi_d, lo_q, lo_d, a_mag, b_mag;
  logic signed [WIDTH-1:0] a_s, b_s;
  logic                    neg_q, neg_d, done_q, done_d;
  logic                    signed_op, mul_op, mul_step, last;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic en);
    return (en && v[WIDTH-1]) ? (~v + 1'b1) : v;
  endfunction

  assign op_e      = muldiv_op_t'(op);
  assign a_s       = a;
  assign b_s       = b;
  assign signed_op = (op_e == OP_MULT) || (op_e == OP_DIV);
  assign mul_op    = (op_e == OP_MULT) || (op_e == OP_MULTU);
  assign a_mag     = magnitude(a, signed_op);
  assign b_mag     = magnitude(b, signed_op);

`ifdef MULDIV_DIV_EN
  logic             rneg_q, rneg_d, dvz_q, dvz_d, div_step;
  logic [WIDTH-1:0] quo_nxt, rem_nxt;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  muldiv_divider #(.WIDTH(WIDTH)) u_div (
    .clk        (clk),
    .rst        (reset),
    .load_i     (start && (state_q == ST_IDLE) && !mul_op),
    .step_i     (div_step),
    .dividend_i (a_mag),
    .divisor_i  (b_mag),
    .quo_nxt_o  (quo_nxt),
    .rem_nxt_o  (rem_nxt)
  );
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start && mul_op) state_d = ST_MUL;
`ifdef MULDIV_DIV_EN
        if (start && !mul_op) state_d = ST_DIV;
`endif
      end
      ST_MUL:  if (last) state_d = ST_IDLE;
`ifdef MULDIV_DIV_EN
      ST_DIV:  if (last) state_d = ST_IDLE;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = 1'b0;
    mul_step = 1'b0;
    last     = 1'b0;
`ifdef MULDIV_DIV_EN
    div_step = 1'b0;
`endif
    case (state_q)
      ST_MUL: begin
        busy     = 1'b1;
        mul_step = 1'b1;
        last     = (cnt_q == CNT_LAST);
      end
`ifdef MULDIV_DIV_EN
      ST_DIV: begin
        busy     = 1'b1;
        div_step = 1'b1;
        last     = (cnt_q == CNT_LAST);
      end
`endif
      default: ;
    endcase
  end

  // Shift-add: conditionally add the multiplicand into the upper half, then shift right.
  always_comb begin
    psum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    acc_step = {psum, acc_q[WIDTH-1:1]};
    prod     = neg_q ? (~acc_step + 1'b1) : acc_step;
  end

  always_comb begin
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    neg_d   = neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
`ifdef MULDIV_DIV_EN
    rneg_d  = rneg_q;
    dvz_d   = dvz_q;
`endif
    if (state_q == ST_IDLE) begin
      if (hi_we) hi_d = wdata;
      if (lo_we) lo_d = wdata;
      if (start) begin
        cnt_d = '0;
        if (mul_op) begin
          acc_d   = {{WIDTH{1'b0}}, b_mag};
          mcand_d = a_mag;
          neg_d   = signed_op && (a_s[WIDTH-1] ^ b_s[WIDTH-1]);
        end else begin
`ifdef MULDIV_DIV_EN
          neg_d  = signed_op && (a_s[WIDTH-1] ^ b_s[WIDTH-1]);
          rneg_d = signed_op && a_s[WIDTH-1];
          dvz_d  = (b == '0);
`else
          done_d = 1'b1;
`endif
        end
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
      if (mul_step) acc_d = acc_step;
      if (last) begin
        done_d = 1'b1;
        if (mul_step) begin
          {hi_d, lo_d} = prod;
        end
`ifdef MULDIV_DIV_EN
        if (div_step) begin
          hi_d = cond_neg(rem_nxt, rneg_q);
          lo_d = dvz_q ? MULDIV_DIV0_LO : cond_neg(quo_nxt, neg_q);
        end
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      neg_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
`ifdef MULDIV_DIV_EN
      rneg_q  <= 1'b0;
      dvz_q   <= 1'b0;
`endif
    end else begin
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      neg_q   <= neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
`ifdef MULDIV_DIV_EN
      rneg_q  <= rneg_d;
      dvz_q   <= dvz_d;
`endif
    end
  end

  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
